// File: rtl/alu_pkg.sv
// Shared opcode and FSM state definitions for the execute unit and the ALU decoder.
package alu_pkg;

    // ALU operation codes driven by the decoder on ALUControl
    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_SLL  = 4'b0010;
    localparam logic [3:0] ALU_SLT  = 4'b0011;
    localparam logic [3:0] ALU_SLTU = 4'b0100;
    localparam logic [3:0] ALU_XOR  = 4'b0101;
    localparam logic [3:0] ALU_SHR  = 4'b0110;  // SRL, or SRA when ShiftArith=1
    localparam logic [3:0] ALU_OR   = 4'b1000;
    localparam logic [3:0] ALU_AND  = 4'b1001;

    // Sequencer states
    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_SHIFT = 2'b01;
    localparam logic [1:0] ST_DONE  = 2'b10;

    // True for the codes handled by the serial shifter
    function automatic logic is_shift_op(input logic [3:0] op);
        return (op == ALU_SLL) || (op == ALU_SHR);
    endfunction

endpackage

// File: rtl/alu_comb.sv
// Single-cycle ALU operations; shift and unused codes produce 0 (shifts run serially upstream).
module alu_comb
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [3:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] result_o
);

    // Decode the operation code into a combinational result
    always_comb begin
        result_o = '0;
        unique case (op_i)
            ALU_ADD:  result_o = a_i + b_i;
            ALU_SUB:  result_o = a_i - b_i;
            ALU_SLT:  result_o = {{(WIDTH-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
            ALU_SLTU: result_o = {{(WIDTH-1){1'b0}}, (a_i < b_i)};
            ALU_XOR:  result_o = a_i ^ b_i;
            ALU_OR:   result_o = a_i | b_i;
            ALU_AND:  result_o = a_i & b_i;
            default:  result_o = '0;
        endcase
    end

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle execute unit: single-cycle ops in one registered cycle, shifts one bit per cycle.
module seq_alu
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       ALUControl,
    input  logic             ShiftArith,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic [WIDTH-1:0] ALUResult,
    output logic             Zero,
    output logic             busy,
    output logic             done
);

    localparam int unsigned SW = $clog2(WIDTH);
    localparam logic [SW-1:0] CntOne = 1;

    logic [1:0]       state_q, state_d;
    logic [SW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic             left_q, left_d;
    logic             arith_q, arith_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;

    logic [WIDTH-1:0] comb_result;
    logic [WIDTH-1:0] sh_step;
    logic [SW-1:0]    shamt;
    logic             accept;

    alu_comb #(
        .WIDTH (WIDTH)
    ) u_alu_comb (
        .op_i     (ALUControl),
        .a_i      (SrcA),
        .b_i      (SrcB),
        .result_o (comb_result)
    );

    assign shamt  = SrcB[SW-1:0];
    assign accept = start && (state_q != ST_SHIFT);

    // One-bit shift of the working register; SRA replicates the current MSB
    always_comb begin
        if (left_q) begin
            sh_step = {sh_q[WIDTH-2:0], 1'b0};
        end else begin
            sh_step = {arith_q & sh_q[WIDTH-1], sh_q[WIDTH-1:1]};
        end
    end

    // Next-state logic: accept from IDLE/DONE, iterate in SHIFT, retire through DONE
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sh_d     = sh_q;
        left_d   = left_q;
        arith_d  = arith_q;
        result_d = result_q;
        zero_d   = zero_q;

        if (accept) begin
            if (is_shift_op(ALUControl)) begin
                if (shamt == '0) begin
                    result_d = SrcA;
                    zero_d   = (SrcA == '0);
                    state_d  = ST_DONE;
                end else begin
                    sh_d    = SrcA;
                    cnt_d   = shamt;
                    left_d  = (ALUControl == ALU_SLL);
                    arith_d = (ALUControl == ALU_SHR) && ShiftArith;
                    state_d = ST_SHIFT;
                end
            end else begin
                result_d = comb_result;
                zero_d   = (comb_result == '0);
                state_d  = ST_DONE;
            end
        end else if (state_q == ST_SHIFT) begin
            sh_d  = sh_step;
            cnt_d = cnt_q - CntOne;
            if (cnt_q == CntOne) begin
                result_d = sh_step;
                zero_d   = (sh_step == '0);
                state_d  = ST_DONE;
            end
        end else if (state_q == ST_DONE) begin
            state_d = ST_IDLE;
        end
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            sh_q     <= '0;
            left_q   <= 1'b0;
            arith_q  <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sh_q     <= sh_d;
            left_q   <= left_d;
            arith_q  <= arith_d;
            result_q <= result_d;
            zero_q   <= zero_d;
        end
    end

    assign ALUResult = result_q;
    assign Zero      = zero_q;
    assign busy      = (state_q == ST_SHIFT);
    assign done      = (state_q == ST_DONE);

endmodule
